multi_channel_debouncer: RTL and testbench
==========================================

// Module: multi_channel_debouncer
// PURPOSE
//  Parametrised successor to the two-channel clear-debounce block: N independent
//  channels of switch/button debouncing in one clocked unit.
//  Each raw input is synchronised, then qualified by a stable-count filter.
//  Outputs per channel: a clean level plus one-cycle rise/fall pulses.
//  Sits between board pushbuttons/switches and the control FSMs.
// PARAMETERS
//  CHANNELS      2      number of independent input channels (>=1)
//  SYNC_STAGES   2      synchroniser flop depth (>=2)
//  STABLE_COUNT  20000  consecutive cycles a new level must hold before acceptance (>=1)
//  CNT_WIDTH     16     per-channel counter width; must hold STABLE_COUNT-1
//  RESET_LEVEL   1'b0   value of the synchronisers and the debounced level after reset
// PORTS
//  clk      in   1         system clock; all state on rising edge
//  rst_n    in   1         asynchronous, active-low reset
//  in       in   CHANNELS  raw, asynchronous, bouncing inputs
//  en       in   CHANNELS  per-channel enable; 0 = channel frozen
//  out      out  CHANNELS  debounced level
//  rise     out  CHANNELS  1-cycle pulse when out[i] goes 0->1
//  fall     out  CHANNELS  1-cycle pulse when out[i] goes 1->0
//  busy     out  CHANNELS  1 while channel i's counter is nonzero (qualifying a change)
// BEHAVIOUR
//  Reset (rst_n=0, async): sync chains=RESET_LEVEL, out=RESET_LEVEL, counters=0,
//   rise=fall=0, busy=0. Release is synchronous to the next clk edge.
//  Synchroniser: in[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
//   The synchroniser runs regardless of en.
//  Per channel i, each rising edge, in priority order:
//   1. en[i]=0: cnt<=0; out[i] holds; rise/fall=0.
//   2. s[i]==out[i]: cnt<=0 (any bounce back to the old level restarts qualification).
//   3. cnt==STABLE_COUNT-1: out[i]<=s[i]; cnt<=0; rise[i] or fall[i]<=1 on the same edge.
//   4. else: cnt<=cnt+1.
//  rise/fall are registered. Each is high for exactly one cycle, coincident with the
//   first cycle of the new out level. rise and fall are never both high on one channel.
//  busy[i] = (cnt!=0); it is combinational from the counter register.
//  Latency: a clean level change on in[i] appears on out[i] at the
//   (SYNC_STAGES+STABLE_COUNT)-th rising edge. Edge 1 is the first edge that samples
//   the new level. Example: defaults give 20002 cycles.
//  Glitch rejection: a level shorter than STABLE_COUNT cycles at s[i] never reaches out.
//  STABLE_COUNT=1: out follows s[i] one edge later; every change is pulsed.
//  The counter cannot wrap: it is cleared at STABLE_COUNT-1.
//   Elaboration fails if 2**CNT_WIDTH < STABLE_COUNT, or if SYNC_STAGES<2.
//  Deassertion of en[i] mid-qualification discards progress. Reasserting en[i] restarts
//   from cnt=0, even if s[i] already differs from out[i].
//  Asserting rst_n=0 mid-qualification clears everything within the same cycle; no pulse
//   is emitted.
//  Channels are fully independent. Simultaneous events on different channels each behave
//   as if alone.
// TESTING (bench parameters: CHANNELS=2, SYNC_STAGES=2, STABLE_COUNT=8, CNT_WIDTH=4)
//  1 Reset: rst_n=0 with in=2'b11 -> out=00, rise=fall=busy=00. After release with in
//    held at 11: out=11 at edge 10, with rise=11 for exactly that one cycle.
//  2 Bounce: in[0] toggles 1,0,1,0 every 3 cycles, then holds 1 -> out[0] rises exactly
//    10 edges after the final 0->1, one rise pulse only, busy[0] toggling during bounce.
//  3 Glitch: in[1]=1 for 7 cycles then 0 -> out[1] stays 0, no pulses, busy[1] returns 0.
//  4 Release: with out[0]=1, drive in[0]=0 -> fall[0] pulses at edge 10, out[0]=0.
//  5 Enable: start a change on ch0, drop en[0] at cnt=5 for 3 cycles, then raise it ->
//    out[0] changes 8 edges after en[0] returns. ch1 is unaffected throughout.
//  6 Async reset: assert rst_n between edges at cnt=6 -> out, cnt, busy clear
//    immediately with no pulse. A full 10-edge requalification is needed after release.

Source files
------------

// File: rtl/multi_channel_debouncer.sv
// N-channel switch debouncer: each raw input is synchronised, then accepted only after
// holding a new level for STABLE_COUNT consecutive cycles. Emits level plus rise/fall pulses.
module multi_channel_debouncer #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_COUNT = 20000,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter logic        RESET_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_i,
    input  logic [CHANNELS-1:0] en_i,
    output logic [CHANNELS-1:0] out_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] busy_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("CHANNELS must be at least 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if ((STABLE_COUNT < 1) || ((64'd1 << CNT_WIDTH) < 64'(STABLE_COUNT))) begin : g_bad_cnt
            $error("CNT_WIDTH too small for STABLE_COUNT, or STABLE_COUNT is zero");
        end
    endgenerate

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  out_q, out_d;
    logic [CHANNELS-1:0]                  rise_q, rise_d;
    logic [CHANNELS-1:0]                  fall_q, fall_d;
    logic [CHANNELS-1:0]                  sync_s;

    // Synchroniser shift and per-channel qualification, independent of every other channel.
    always_comb begin
        sync_d = sync_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        sync_s = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], in_i[i]};
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
            if (!en_i[i]) begin
                cnt_d[i] = '0;
            end else if (sync_s[i] == out_q[i]) begin
                // A bounce back to the accepted level restarts qualification.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]  = '0;
                out_d[i]  = sync_s[i];
                rise_d[i] = sync_s[i];
                fall_d[i] = ~sync_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {(CHANNELS*SYNC_STAGES){RESET_LEVEL}};
            cnt_q  <= '0;
            out_q  <= {CHANNELS{RESET_LEVEL}};
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // busy tracks the counter register directly.
    always_comb begin
        busy_o = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            busy_o[i] = (cnt_q[i] != '0);
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: reset table, directed corner sequences and randomized
// traffic, all compared against a window-based reference model.
module tb_multi_channel_debouncer;
    localparam int CH     = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int CW     = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_i  = 2'b11;
    logic [1:0] en_i  = 2'b11;
    logic [1:0] out_o, rise_o, fall_o, busy_o;

    int nchecks = 0;
    int nerrors = 0;
    int cyc     = 0;

    multi_channel_debouncer #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_COUNT(STABLE), .CNT_WIDTH(CW),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_i(in_i), .en_i(en_i),
        .out_o(out_o), .rise_o(rise_o), .fall_o(fall_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] out;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] busy;
    } obs_t;

    // Reference model: history of sampled inputs since reset. A channel accepts a new level
    // when the synchronised value differed from out, with en high, on each of the last
    // STABLE edges.
    logic [1:0] h_in[$];
    logic [1:0] h_en[$];
    obs_t       m = '0;

    function automatic logic s_at(input int ch, input int j);
        if (j < SYNC) return 1'b0;
        return h_in[j-SYNC][ch];
    endfunction

    function automatic obs_t model_eval(input obs_t prev);
        obs_t r;
        int   k;
        logic s;
        logic all_ok;
        r      = prev;
        r.rise = '0;
        r.fall = '0;
        r.busy = '0;
        k      = h_in.size() - 1;
        for (int ch = 0; ch < CH; ch++) begin
            s      = s_at(ch, k);
            all_ok = 1'b1;
            for (int j = k - STABLE + 1; j <= k; j++) begin
                if (j < 0) all_ok = 1'b0;
                else if (!h_en[j][ch] || (s_at(ch, j) == prev.out[ch])) all_ok = 1'b0;
            end
            if (all_ok) begin
                r.out[ch]  = s;
                r.rise[ch] = s;
                r.fall[ch] = ~s;
            end else begin
                r.busy[ch] = h_en[k][ch] && (s != prev.out[ch]);
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_in.delete();
            h_en.delete();
            m <= '0;
        end else begin
            h_in.push_back(in_i);
            h_en.push_back(en_i);
            m <= model_eval(m);
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("model_out",  out_o,  m.out);
        check("model_rise", rise_o, m.rise);
        check("model_fall", fall_o, m.fall);
        check("model_busy", busy_o, m.busy);
        check("rise_fall_exclusive", rise_o & fall_o, 2'b00);
    endtask

    typedef struct packed {
        logic [1:0] in;
        logic [1:0] en;
        logic [1:0] out;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int   nrise;
        logic bhi, blo, any_out, any_pulse;
        int   hold0, hold1;

        // Reset-release table: in=11 held, out rises at edge 10 with a single rise pulse.
        for (int t = 0; t < 12; t++) begin
            tbl[t].in   = 2'b11;
            tbl[t].en   = 2'b11;
            tbl[t].out  = (t >= 9) ? 2'b11 : 2'b00;
            tbl[t].rise = (t == 9) ? 2'b11 : 2'b00;
            tbl[t].fall = 2'b00;
            tbl[t].busy = (t >= 2 && t <= 8) ? 2'b11 : 2'b00;
        end

        rst_n = 1'b0;
        in_i  = 2'b11;
        en_i  = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out",  out_o,  2'b00);
        check("reset_rise", rise_o, 2'b00);
        check("reset_fall", fall_o, 2'b00);
        check("reset_busy", busy_o, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            in_i = tbl[t].in;
            en_i = tbl[t].en;
            tick();
            check("tbl_out",  out_o,  tbl[t].out);
            check("tbl_rise", rise_o, tbl[t].rise);
            check("tbl_fall", fall_o, tbl[t].fall);
            check("tbl_busy", busy_o, tbl[t].busy);
        end

        // Release on ch0: fall pulse at edge 10.
        in_i = 2'b10;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check("rel_fall0", 2'(fall_o[0]), 2'(t == 10));
            check("rel_out0",  2'(out_o[0]),  2'(t < 10));
        end

        // Bounce on ch0 (3-cycle phases), then hold 1.
        nrise = 0;
        bhi   = 1'b0;
        blo   = 1'b0;
        for (int p = 0; p < 4; p++) begin
            in_i[0] = (p % 2 == 0);
            repeat (3) begin
                tick();
                nrise += int'(rise_o[0]);
                if (busy_o[0]) bhi = 1'b1;
                else blo = 1'b1;
            end
        end
        check("bounce_no_early_rise", 2'(nrise), 2'b00);
        check("bounce_busy_toggles", {bhi, blo}, 2'b11);
        in_i[0] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check("bounce_rise0", 2'(rise_o[0]), 2'(t == 10));
            check("bounce_out0",  2'(out_o[0]),  2'(t >= 10));
        end

        // Glitch on ch1: first bring out[1] low, then a 7-cycle high pulse.
        in_i[1] = 1'b0;
        repeat (12) tick();
        check("glitch_pre_out1", 2'(out_o[1]), 2'b00);
        any_out   = 1'b0;
        any_pulse = 1'b0;
        in_i[1]   = 1'b1;
        repeat (7) begin
            tick();
            any_out   |= out_o[1];
            any_pulse |= rise_o[1] | fall_o[1];
        end
        in_i[1] = 1'b0;
        repeat (12) begin
            tick();
            any_out   |= out_o[1];
            any_pulse |= rise_o[1] | fall_o[1];
        end
        check("glitch_out1_held", 2'(any_out),   2'b00);
        check("glitch_no_pulse",  2'(any_pulse), 2'b00);
        check("glitch_busy1_idle", 2'(busy_o[1]), 2'b00);

        // Enable drop on ch0 at cnt=5 while ch1 qualifies a rise in parallel.
        in_i = 2'b10;
        repeat (7) tick();
        check("en_busy0_mid", 2'(busy_o[0]), 2'b01);
        en_i[0] = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            check("en_low_busy0", 2'(busy_o[0]), 2'b00);
            check("en_low_out0",  2'(out_o[0]),  2'b01);
            check("en_ch1_rise",  2'(rise_o[1]), 2'(t == 3));
            check("en_ch1_out",   2'(out_o[1]),  2'(t == 3));
        end
        en_i[0] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check("en_back_fall0", 2'(fall_o[0]), 2'(t == 8));
            check("en_back_out0",  2'(out_o[0]),  2'(t < 8));
            check("en_ch1_steady", 2'(out_o[1]),  2'b01);
        end

        // Async reset mid-qualification (cnt=6 on ch0).
        in_i = 2'b11;
        repeat (8) tick();
        check("arst_busy0_pre", 2'(busy_o[0]), 2'b01);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out",  out_o,  2'b00);
        check("arst_busy", busy_o, 2'b00);
        check("arst_rise", rise_o, 2'b00);
        check("arst_fall", fall_o, 2'b00);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check("arst_requal_rise", rise_o, (t == 10) ? 2'b11 : 2'b00);
            check("arst_requal_out",  out_o,  (t >= 10) ? 2'b11 : 2'b00);
        end

        // Randomized traffic: random hold lengths around STABLE, occasional enable drops.
        hold0 = 0;
        hold1 = 0;
        for (int t = 0; t < 3000; t++) begin
            if (hold0 == 0) begin
                in_i[0] = 1'($urandom_range(0, 1));
                hold0   = int'($urandom_range(1, 14));
            end else begin
                hold0--;
            end
            if (hold1 == 0) begin
                in_i[1] = 1'($urandom_range(0, 1));
                hold1   = int'($urandom_range(1, 14));
            end else begin
                hold1--;
            end
            en_i = ($urandom_range(0, 24) == 0) ? 2'($urandom) : 2'b11;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
